// File: rtl/rb2_arbiter.sv
// RB2 register-bank port owner: round-robin arbitration of writer/reader, write bitmap, bank-full and read-miss.
// Optional RB2_ARB_FIXED_PRI_EN: writer always wins ties (reader may starve).
module rb2_arbiter #(
    parameter int AW = 3,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_miss,
    input  logic          map_clr,
    output logic          bank_full,
    output logic          RB2_RW,
    output logic [AW-1:0] RB2_A,
    output logic [DW-1:0] RB2_D,
    input  logic [DW-1:0] RB2_Q
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state, state_nxt;
    logic              last_r, last_r_nxt;   // 1: most recent grant went to the reader
    logic [DEPTH-1:0]  bitmap, bitmap_nxt;
    logic              rw_nxt, wr_gnt_nxt, rd_gnt_nxt, rd_valid_nxt, rd_miss_nxt;
    logic [AW-1:0]     a_nxt;
    logic [DW-1:0]     d_nxt, rd_data_nxt;
    logic              pick_w, pick_r;

`ifdef RB2_ARB_FIXED_PRI_EN
    assign pick_w = wr_req;
`else
    assign pick_w = wr_req && (!rd_req || last_r);
`endif
    assign pick_r = rd_req && !pick_w;

    always_comb begin
        state_nxt    = state;
        last_r_nxt   = last_r;
        rw_nxt       = 1'b1;
        a_nxt        = RB2_A;
        d_nxt        = RB2_D;
        wr_gnt_nxt   = 1'b0;
        rd_gnt_nxt   = 1'b0;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = rd_data;
        rd_miss_nxt  = rd_miss;
        // Clear is applied before any set from a completing write.
        bitmap_nxt   = map_clr ? '0 : bitmap;
        case (state)
            IDLE: begin
                if (pick_w) begin
                    state_nxt  = WR;
                    a_nxt      = wr_addr;
                    d_nxt      = wr_data;
                    rw_nxt     = 1'b0;
                    wr_gnt_nxt = 1'b1;
                    last_r_nxt = 1'b0;
                end else if (pick_r) begin
                    state_nxt  = RD;
                    a_nxt      = rd_addr;
                    rd_gnt_nxt = 1'b1;
                    last_r_nxt = 1'b1;
                end
            end
            WR: begin
                state_nxt         = IDLE;
                bitmap_nxt[RB2_A] = 1'b1;
            end
            RD: begin
                state_nxt    = IDLE;
                rd_data_nxt  = RB2_Q;
                rd_miss_nxt  = ~bitmap[RB2_A];
                rd_valid_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_r    <= 1'b1;
            bitmap    <= '0;
            bank_full <= 1'b0;
            RB2_RW    <= 1'b1;
            RB2_A     <= '0;
            RB2_D     <= '0;
            wr_gnt    <= 1'b0;
            rd_gnt    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_miss   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_r    <= last_r_nxt;
            bitmap    <= bitmap_nxt;
            bank_full <= &bitmap;
            RB2_RW    <= rw_nxt;
            RB2_A     <= a_nxt;
            RB2_D     <= d_nxt;
            wr_gnt    <= wr_gnt_nxt;
            rd_gnt    <= rd_gnt_nxt;
            rd_valid  <= rd_valid_nxt;
            rd_data   <= rd_data_nxt;
            rd_miss   <= rd_miss_nxt;
        end
    end
endmodule

// File: tb/tb_rb2_arbiter.sv
// Bench for rb2_arbiter: bank model, read scoreboard queue, arbitration order, bitmap and reset cases.
module tb_rb2_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req, map_clr;
    logic [2:0]  wr_addr, rd_addr;
    logic [17:0] wr_data;
    logic        wr_gnt, rd_gnt, rd_valid, rd_miss, bank_full;
    logic [17:0] rd_data;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D, RB2_Q;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [17:0] d;
        logic        m;
    } exp_t;
    exp_t sbq[$];

    logic [17:0] bank [8];
    logic [7:0]  mmap;

    always #5 clk = ~clk;

    rb2_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss),
        .map_clr(map_clr), .bank_full(bank_full),
        .RB2_RW(RB2_RW), .RB2_A(RB2_A), .RB2_D(RB2_D), .RB2_Q(RB2_Q)
    );

    assign RB2_Q = bank[RB2_A];
    always @(posedge clk) if (RB2_RW == 1'b0) bank[RB2_A] <= RB2_D;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rd_data", {14'd0, rd_data}, {14'd0, e.d});
                chk("rd_miss", {31'd0, rd_miss}, {31'd0, e.m});
            end
        end
    end

    task automatic wait_gnt(input bit is_rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_rd ? rd_gnt : wr_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [17:0] d, input logic clr);
        bit ok;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        wait_gnt(1'b0, ok);
        wr_req = 1'b0;
        if (ok) begin
            chk("wr_rw", {31'd0, RB2_RW}, 0);
            chk("wr_a", {29'd0, RB2_A}, {29'd0, a});
            chk("wr_d", {14'd0, RB2_D}, {14'd0, d});
            map_clr = clr;
            @(negedge clk);
            map_clr = 1'b0;
            mmap = clr ? (8'b1 << a) : (mmap | (8'b1 << a));
            chk("wr_done_rw", {31'd0, RB2_RW}, 1);
            chk("wr_gnt_pulse", {31'd0, wr_gnt}, 0);
            chk("wr_bitmap", {24'd0, dut.bitmap}, {24'd0, mmap});
        end
    endtask

    task automatic do_rd(input logic [2:0] a, input logic [17:0] ed);
        bit ok;
        exp_t e;
        e.d = ed; e.m = ~mmap[a];
        sbq.push_back(e);
        rd_addr = a; rd_req = 1'b1;
        wait_gnt(1'b1, ok);
        rd_req = 1'b0;
        if (ok) begin
            chk("rd_a", {29'd0, RB2_A}, {29'd0, a});
            chk("rd_rw", {31'd0, RB2_RW}, 1);
            @(negedge clk);
            chk("rd_valid", {31'd0, rd_valid}, 1);
            chk("rd_gnt_pulse", {31'd0, rd_gnt}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string got_seq, exp_seq;
        bit ok;
        for (int i = 0; i < 8; i++) bank[i] = '0;
        mmap = '0;
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; map_clr = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rw", {31'd0, RB2_RW}, 1);
        chk("rst_a", {29'd0, RB2_A}, 0);
        chk("rst_d", {14'd0, RB2_D}, 0);
        chk("rst_gnts", {30'd0, wr_gnt, rd_gnt}, 0);
        chk("rst_rdv", {31'd0, rd_valid}, 0);
        chk("rst_rdd", {14'd0, rd_data}, 0);
        chk("rst_full", {31'd0, bank_full}, 0);
        chk("rst_map", {24'd0, dut.bitmap}, 0);
        rst = 1'b0;

        // basic write then hit/miss reads
        do_wr(3'd3, 18'h2A5A5, 1'b0);
        chk("map_after_w3", {24'd0, dut.bitmap}, 32'h08);
        do_rd(3'd3, 18'h2A5A5);
        do_rd(3'd5, 18'h00000);

        // both requesters contending
`ifdef RB2_ARB_FIXED_PRI_EN
        exp_seq = "WWWW";
`else
        exp_seq = "WRWR";
`endif
        got_seq = "";
        wr_addr = 3'd1; wr_data = 18'h01111; rd_addr = 3'd3;
        for (int g = 0; g < 4; g++) begin
            wr_req = 1'b1; rd_req = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (wr_gnt) begin
                    ok = 1'b1; got_seq = {got_seq, "W"}; wr_req = 1'b0;
                    mmap[1] = 1'b1;
                end else if (rd_gnt) begin
                    exp_t e;
                    ok = 1'b1; got_seq = {got_seq, "R"}; rd_req = 1'b0;
                    e.d = 18'h2A5A5; e.m = 1'b0;
                    sbq.push_back(e);
                end
            end
            if (!ok) chk("arb_timeout", 0, 1);
            if (g == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
            @(negedge clk);
        end
        chk("arb_order", (got_seq == exp_seq) ? 32'd1 : 32'd0, 1);
        @(negedge clk);

        // fill bank, bank_full lags bitmap by a cycle
        for (int a = 0; a < 8; a++) do_wr(a[2:0], 18'h00100 + 18'(a), 1'b0);
        chk("full_lag", {31'd0, bank_full}, 0);
        @(negedge clk);
        chk("full_set", {31'd0, bank_full}, 1);
        do_wr(3'd2, 18'h3FFFF, 1'b0);
        chk("full_rewrite", {31'd0, bank_full}, 1);
        map_clr = 1'b1;
        @(negedge clk);
        map_clr = 1'b0; mmap = '0;
        chk("clr_map", {24'd0, dut.bitmap}, 0);
        @(negedge clk);
        chk("clr_full", {31'd0, bank_full}, 0);
        do_wr(3'd4, 18'h04444, 1'b1);
        chk("clr_wr_map", {24'd0, dut.bitmap}, 32'h10);
        do_rd(3'd2, 18'h3FFFF);

        // reset in the middle of a write
        wr_addr = 3'd6; wr_data = 18'h06666; wr_req = 1'b1;
        wait_gnt(1'b0, ok);
        rst = 1'b1; wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; mmap = '0;
        chk("mid_rst_rw", {31'd0, RB2_RW}, 1);
        chk("mid_rst_gnt", {31'd0, wr_gnt}, 0);
        chk("mid_rst_map", {24'd0, dut.bitmap}, 0);
        do_rd(3'd6, bank[6]);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
